gemv_engine: RTL
================

# gemv_engine

Parametrised matrix-vector engine that replaces the fixed 8x8 systolic datapath with a generic outer-product accumulator. It streams one weight column (ARRAY_SIZE signed elements) and one vector element per cycle from the weight and vector SRAMs, accumulates K_DEPTH columns per data set, and runs DATA_SET consecutive vectors per start. Each finished result leaves through a valid/ready port with a quantised write address. It sits between the input SRAMs and the result-SRAM writer and absorbs the controller, address generator, accumulator and quantiser into one sequential block.

## Interface
- ARRAY_SIZE, 8, output rows, i.e. accumulator lanes
- DATA_WIDTH, 8, signed weight/vector element width
- K_DEPTH, 8, columns accumulated per data set (>=1)
- DATA_SET, 1, vectors processed per start (>=1)
- OUTCOME_WIDTH, 32, accumulator width (>= 2*DATA_WIDTH)
- OUTPUT_DATA_WIDTH, 16, quantised output element width
- W_ADDR_WIDTH, 6 / V_ADDR_WIDTH, 5 / OUT_ADDR_WIDTH, 6, SRAM address widths

Ports:
- clk  in  1  sole clock, rising edge
- srst  in  1  asynchronous, active-high reset
- start  in  1  start pulse; sampled only in IDLE
- shift  in  5  arithmetic right shift applied before quantisation; sampled at start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result transfers
- sram_raddr_w  out  W_ADDR_WIDTH  weight column address
- sram_rdata_w  in  ARRAY_SIZE*DATA_WIDTH  weight column; lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- sram_raddr_v  out  V_ADDR_WIDTH  vector element address
- sram_rdata_v  in  DATA_WIDTH  vector element
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_data  out  ARRAY_SIZE*OUTPUT_DATA_WIDTH  quantised result lanes
- out_addr  out  OUT_ADDR_WIDTH  result write address, equal to the data-set index
- mul_outcome  out  ARRAY_SIZE*OUTCOME_WIDTH  raw accumulators

## Operation
- FSM states are IDLE, RUN, DRAIN, OUT and DONE.
- IDLE -> RUN on start. This transition clears set index s, column counter k and all accumulators, and latches shift.
- RUN: issues sram_raddr_w = k and sram_raddr_v = s*K_DEPTH + k. k increments each cycle. After k = K_DEPTH-1 the FSM goes to DRAIN.
- SRAM read latency is 1 cycle. An internal rd_valid is the RUN flag delayed one cycle.
- When rd_valid is high, each lane updates acc[i] += sext(w[i]*v). The product is signed 2*DATA_WIDTH, sign-extended to OUTCOME_WIDTH, and the accumulator wraps modulo 2^OUTCOME_WIDTH.
- DRAIN performs the final MAC, then the FSM goes to OUT.
- OUT: out_valid = 1. out_data, out_addr and mul_outcome hold stable while out_valid && !out_ready.
- On a transfer (out_valid && out_ready), if s < DATA_SET-1: s++, k = 0, accumulators cleared, FSM goes to RUN. Otherwise the FSM goes to DONE.
- DONE: done = 1 for one cycle, then IDLE. Accumulators keep their last value in IDLE.
- start while busy is ignored.
- Quantisation per lane is q = acc[i] >>> shift. Narrowing to OUTPUT_DATA_WIDTH is covered under Configuration.
- Weights are shared across data sets. Only the vector address advances with s.

## Timing
- Reset values: busy, done and out_valid are 0. Both SRAM addresses, out_addr, out_data and mul_outcome are 0. FSM is in IDLE.
- srst mid-operation aborts immediately. No result or done is produced.
- start is sampled at edge 0:
  - RUN occupies cycles 1..K_DEPTH.
  - MACs occur at the ends of cycles 2..K_DEPTH+1.
  - out_valid rises in cycle K_DEPTH+2.
- With out_ready held high, each later set adds K_DEPTH+2 cycles. Total from start to done is DATA_SET*(K_DEPTH+2)+1 cycles.
- out_ready stalls cost one cycle each. No address is issued in OUT.
- K_DEPTH = 1: RUN lasts one cycle, followed by DRAIN.
- SRAM addresses outside RUN hold their last value.

## Configuration
- GEMV_SAT_EN defined: q saturates to [-2^(OUTPUT_DATA_WIDTH-1), 2^(OUTPUT_DATA_WIDTH-1)-1].
- GEMV_SAT_EN undefined: q is truncated to its low OUTPUT_DATA_WIDTH bits (wrap).

## Structure
- Package gemv_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, OUT, DONE)
  - localparam PROD_WIDTH = 2*DATA_WIDTH
  - functions sext_prod() and quant()
- One sub-module, gemv_lane, is instantiated ARRAY_SIZE times via generate. It contains one MAC, the accumulator and the quantiser, with inputs clear, en, w, v and shift.

## Test plan
- K_DEPTH=8, DATA_SET=1, all weights 1, v = 1..8, shift 0 -> every lane is 36; out_valid in cycle 10; done in cycle 11.
- Weights -128, v = -128 for all k, K_DEPTH=8, shift 0 -> acc = 131072. With GEMV_SAT_EN, out_data lanes are 32767; without it, lanes are 0. mul_outcome shows 131072.
- DATA_SET=3, v_set[s] all equal s+1, weights 2 -> out_addr 0,1,2 with lane values 16, 32, 48. Vector addresses are 0-7, 8-15, 16-23.
- out_ready held low 5 cycles in OUT -> out_data and out_addr are stable, no SRAM addresses change, and done is delayed by 5 cycles.
- Pulse srst during RUN of set 1 -> all outputs are 0 and IDLE is reached. A following start produces set 0 correctly.
- start pulsed during RUN and OUT -> ignored; exactly DATA_SET transfers and one done.

Source files
------------

// File: rtl/gemv_pkg.sv
// Shared types and arithmetic helpers for the gemv_engine matrix-vector datapath.
// GEMV_SAT_EN selects saturating (defined) or wrapping (undefined) output quantisation.
package gemv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    DRAIN = 3'd2,
    OUT   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int PROD_WIDTH     = 2 * DEF_DATA_WIDTH;

  // Sign-extend the low pw bits of p to the full 64-bit container.
  function automatic logic signed [63:0] sext_prod(input logic signed [63:0] p, input int pw);
    return (p <<< (64 - pw)) >>> (64 - pw);
  endfunction

  // Arithmetic shift, then clamp to an ow-bit signed range when saturation is built in;
  // otherwise the caller's truncation to ow bits provides the wrap.
  function automatic logic signed [63:0] quant(input logic signed [63:0] a,
                                               input logic [4:0] sh, input int ow);
    logic signed [63:0] q;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    q  = a >>> sh;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
`ifdef GEMV_SAT_EN
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
`endif
    return q;
  endfunction

endpackage

// File: rtl/gemv_lane.sv
// One accumulator lane of gemv_engine: signed MAC, wrapping accumulator and output quantiser.
// Quantiser behaviour follows GEMV_SAT_EN through gemv_pkg::quant.
module gemv_lane
  import gemv_pkg::*;
#(
  parameter int DATA_WIDTH        = 8,
  parameter int OUTCOME_WIDTH     = 32,
  parameter int OUTPUT_DATA_WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                srst,
  input  logic                                clear,
  input  logic                                en,
  input  logic signed [DATA_WIDTH-1:0]        w,
  input  logic signed [DATA_WIDTH-1:0]        v,
  input  logic        [4:0]                   shift,
  output logic signed [OUTCOME_WIDTH-1:0]     acc,
  output logic signed [OUTPUT_DATA_WIDTH-1:0] q
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]            prod_p0;
  logic signed [OUTCOME_WIDTH-1:0] prod_ext_p0;

  assign prod_p0     = PW'(w) * PW'(v);
  assign prod_ext_p0 = OUTCOME_WIDTH'(sext_prod(64'($unsigned(prod_p0)), PW));

  // Stage boundary: accumulator register, wraps modulo 2^OUTCOME_WIDTH.
  always_ff @(posedge clk or posedge srst) begin
    if (srst)       acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc + prod_ext_p0;
  end

  assign q = OUTPUT_DATA_WIDTH'(quant(64'(acc), shift, OUTPUT_DATA_WIDTH));

endmodule

// File: rtl/gemv_engine.sv
// Outer-product matrix-vector engine: streams weight columns and vector elements, accumulates
// K_DEPTH columns per data set and emits quantised rows over valid/ready. Option: GEMV_SAT_EN.
module gemv_engine
  import gemv_pkg::*;
#(
  parameter int ARRAY_SIZE        = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int K_DEPTH           = 8,
  parameter int DATA_SET          = 1,
  parameter int OUTCOME_WIDTH     = 32,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int W_ADDR_WIDTH      = 6,
  parameter int V_ADDR_WIDTH      = 5,
  parameter int OUT_ADDR_WIDTH    = 6
) (
  input  logic                                      clk,
  input  logic                                      srst,
  input  logic                                      start,
  input  logic [4:0]                                shift,
  output logic                                      busy,
  output logic                                      done,
  output logic [W_ADDR_WIDTH-1:0]                   sram_raddr_w,
  input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]          sram_rdata_w,
  output logic [V_ADDR_WIDTH-1:0]                   sram_raddr_v,
  input  logic [DATA_WIDTH-1:0]                     sram_rdata_v,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0]   out_data,
  output logic [OUT_ADDR_WIDTH-1:0]                 out_addr,
  output logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0]       mul_outcome
);

  localparam int KW = (K_DEPTH > 1) ? $clog2(K_DEPTH) : 1;

  state_t                    state_q, state_d;
  logic [KW-1:0]             k;
  logic [OUT_ADDR_WIDTH-1:0] s;
  logic [4:0]                shift_q;
  logic                      rd_valid;
  logic                      start_run, next_set;
  logic                      last_k, last_set;

  assign last_k   = (int'(k) == K_DEPTH - 1);
  assign last_set = (int'(s) == DATA_SET - 1);

  always_comb begin
    state_d   = state_q;
    start_run = 1'b0;
    next_set  = 1'b0;
    case (state_q)
      IDLE:  if (start) begin
               state_d   = RUN;
               start_run = 1'b1;
             end
      RUN:   if (last_k) state_d = DRAIN;
      DRAIN: state_d = OUT;
      OUT:   if (out_ready) begin
               if (last_set) state_d = DONE;
               else begin
                 state_d  = RUN;
                 next_set = 1'b1;
               end
             end
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage boundary: control registers; addresses present the column read in the current RUN cycle.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q      <= IDLE;
      k            <= '0;
      s            <= '0;
      shift_q      <= '0;
      rd_valid     <= 1'b0;
      sram_raddr_w <= '0;
      sram_raddr_v <= '0;
    end else begin
      state_q  <= state_d;
      rd_valid <= (state_q == RUN);
      if (start_run) begin
        s            <= '0;
        k            <= '0;
        shift_q      <= shift;
        sram_raddr_w <= '0;
        sram_raddr_v <= '0;
      end else if (next_set) begin
        s            <= s + 1'b1;
        k            <= '0;
        sram_raddr_w <= '0;
        sram_raddr_v <= V_ADDR_WIDTH'((int'(s) + 1) * K_DEPTH);
      end else if (state_q == RUN && !last_k) begin
        k            <= k + 1'b1;
        sram_raddr_w <= sram_raddr_w + 1'b1;
        sram_raddr_v <= sram_raddr_v + 1'b1;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = (state_q == OUT);
  assign out_addr  = s;

  for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
    logic signed [OUTCOME_WIDTH-1:0]     acc_l;
    logic signed [OUTPUT_DATA_WIDTH-1:0] q_l;

    gemv_lane #(
      .DATA_WIDTH       (DATA_WIDTH),
      .OUTCOME_WIDTH    (OUTCOME_WIDTH),
      .OUTPUT_DATA_WIDTH(OUTPUT_DATA_WIDTH)
    ) u_lane (
      .clk  (clk),
      .srst (srst),
      .clear(start_run | next_set),
      .en   (rd_valid),
      .w    (sram_rdata_w[i*DATA_WIDTH +: DATA_WIDTH]),
      .v    (sram_rdata_v),
      .shift(shift_q),
      .acc  (acc_l),
      .q    (q_l)
    );

    assign mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]         = acc_l;
    assign out_data[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH]    = q_l;
  end

endmodule
